vga_timing_receiver: RTL

Receiving end of the 1024x768@60 VGA timing stream produced by `vga`: consumes `hsync`/`vsync`/`blank` (internal active-high polarity, before the top-level inversion) and recovers pixel coordinates, frame-start strobes and a lock indication. It sits on the 65 MHz pixel clock beside the renderer and is used both as a timing checker for the generator and as the coordinate source for downstream capture and overlay logic.

---
 rtl/vga_timing_receiver.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_receiver.sv
// Recovers pixel coordinates, frame-start strobes and a lock indication from
// an active-high hsync/vsync/blank timing stream on the pixel clock.
module vga_timing_receiver #(
  parameter int H_ACTIVE    = 1024,
  parameter int H_TOTAL     = 1344,
  parameter int V_ACTIVE    = 768,
  parameter int V_TOTAL     = 806,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        valid_out,
  output logic        frame_start_out,
  output logic        locked_out,
  output logic [7:0]  err_count_out
);

  typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

  localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
  localparam logic [11:0] H_TOTAL_W  = 12'(H_TOTAL);
  localparam logic [10:0] V_ACTIVE_W = 11'(V_ACTIVE);
  localparam logic [10:0] V_TOTAL_W  = 11'(V_TOTAL);
  localparam logic [7:0]  LOCK_W     = 8'(LOCK_FRAMES);

  state_t      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
  logic [10:0] x_cnt_q, x_cnt_d;
  logic [9:0]  y_cnt_q, y_cnt_d;
  logic [11:0] h_per_q, h_per_d;
  logic        hs_seen_q, hs_seen_d;
  logic [10:0] v_lines_q, v_lines_d;
  logic [10:0] v_act_q, v_act_d;
  logic [7:0]  good_q, good_d;
  logic        frame_bad_q, frame_bad_d;
  logic [10:0] x_out_q, x_out_d;
  logic [9:0]  y_out_q, y_out_d;
  logic        valid_q, valid_d;
  logic        fs_q, fs_d;
  logic        locked_q, locked_d;
  logic [7:0]  err_q, err_d;

  logic        hs_rise, vs_rise, bl_rise, run_end, checking;
  logic        h_err, v_err, lose_lock;
  logic [10:0] v_lines_tot, v_act_tot;

  always_comb begin
    hs_rise  = hsync_in & ~hs_q;
    vs_rise  = vsync_in & ~vs_q;
    bl_rise  = blank_in & ~bl_q;
    // A blank edge only ends a line when that line actually had pixels.
    run_end  = bl_rise && (x_cnt_q != 11'd0);
    checking = (state_q != SEARCH);

    // A line or active run landing on the vsync edge belongs to the ending frame.
    v_lines_tot = (hs_rise && v_lines_q != '1) ? v_lines_q + 11'd1 : v_lines_q;
    v_act_tot   = (run_end && v_act_q != '1)   ? v_act_q + 11'd1   : v_act_q;

    h_err = checking &&
            ((hs_rise && hs_seen_q && (h_per_q != H_TOTAL_W)) ||
             (run_end && (x_cnt_q != H_ACTIVE_W)));
    v_err = checking && vs_rise &&
            ((v_lines_tot != V_TOTAL_W) || (v_act_tot != V_ACTIVE_W));
    lose_lock = (state_q == LOCKED) && (h_err || v_err);

    // NOTE: every _d gets a default first so no path through this block can
    // leave a signal unassigned and infer a latch.
    hs_d        = hsync_in;
    vs_d        = vsync_in;
    bl_d        = blank_in;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    state_d     = state_q;
    good_d      = good_q;
    frame_bad_d = frame_bad_q;
    err_d       = err_q;

    if (blank_in) begin
      x_cnt_d = 11'd0;
    end else begin
      x_out_d = x_cnt_q;
      y_out_d = y_cnt_q;
      x_cnt_d = (x_cnt_q == '1) ? x_cnt_q : x_cnt_q + 11'd1;
    end

    if (vs_rise)
      y_cnt_d = 10'd0;
    else if (run_end && y_cnt_q != '1)
      y_cnt_d = y_cnt_q + 10'd1;

    h_per_d   = hs_rise ? 12'd1 : ((h_per_q == '1) ? h_per_q : h_per_q + 12'd1);
    hs_seen_d = hs_seen_q | hs_rise;
    v_lines_d = vs_rise ? 11'd0 : v_lines_tot;
    v_act_d   = vs_rise ? 11'd0 : v_act_tot;

    case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d     = TRAIN;
          good_d      = 8'd0;
          frame_bad_d = 1'b0;
        end
      end
      TRAIN: begin
        if (h_err) frame_bad_d = 1'b1;
        if (vs_rise) begin
          frame_bad_d = 1'b0;
          if (v_err || h_err || frame_bad_q) begin
            good_d = 8'd0;
          end else begin
            good_d = good_q + 8'd1;
            if (good_d >= LOCK_W) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (lose_lock) begin
          state_d = SEARCH;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase

    valid_d  = ~blank_in && (state_q == LOCKED) && !lose_lock;
    fs_d     = vs_rise && (state_q == LOCKED) && !lose_lock;
    locked_d = (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= SEARCH;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      bl_q        <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      h_per_q     <= '0;
      hs_seen_q   <= 1'b0;
      v_lines_q   <= '0;
      v_act_q     <= '0;
      good_q      <= '0;
      frame_bad_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      valid_q     <= 1'b0;
      fs_q        <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      bl_q        <= bl_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      h_per_q     <= h_per_d;
      hs_seen_q   <= hs_seen_d;
      v_lines_q   <= v_lines_d;
      v_act_q     <= v_act_d;
      good_q      <= good_d;
      frame_bad_q <= frame_bad_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      valid_q     <= valid_d;
      fs_q        <= fs_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign x_out           = x_out_q;
  assign y_out           = y_out_q;
  assign valid_out       = valid_q;
  assign frame_start_out = fs_q;
  assign locked_out      = locked_q;
  assign err_count_out   = err_q;

endmodule
